mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Round-robin arbiter that shares one single-port memory among `N_CORES` requesters. Each core issues one read or write at a time over a req/ack handshake. The arbiter serialises the accesses onto the memory port, waits out a fixed memory read latency, and returns read data with a one-cycle ack. It sits between the core array and the shared data memory.

## Interface
Parameters:
- `N_CORES`, 4: number of requesters, ≥2; any value, not only powers of two.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `READ_LAT`, 1: memory read latency in cycles, ≥1.

Ports:
- `clk`  in  1: the single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  `N_CORES`: per-core request.
- `we`  in  `N_CORES`: per-core write enable; 1 = write, 0 = read.
- `addr`  in  `N_CORES*ADDR_W`: flattened per-core address; core i occupies slice [i*ADDR_W +: ADDR_W].
- `wdata`  in  `N_CORES*DATA_W`: flattened per-core write data.
- `ack`  out  `N_CORES`: one-hot completion pulse, one cycle.
- `rdata`  out  `DATA_W`: read data; valid only in a read-ack cycle.
- `busy`  out  1: arbiter is not in IDLE.
- `mem_addr`  out  `ADDR_W`: memory address.
- `mem_wdata`  out  `DATA_W`: memory write data.
- `mem_wren`  out  1: memory write strobe.
- `mem_rdata`  in  `DATA_W`: memory read data.

## Operation
- **Requester rule:** hold `req[i]`, `we[i]`, `addr[i]` and `wdata[i]` stable until `ack[i]`. If `req[i]` is high in the cycle after `ack[i]`, that is a new request.
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **IDLE:**
  - If any `req` is high, select the first requester at index ≥ `ptr`, wrapping modulo `N_CORES`.
  - Register `sel`, `mem_addr` and `mem_wdata`. Set `mem_wren` to `we[sel]`. Go to ACCESS.
  - Set `ptr` to (`sel`+1) mod `N_CORES`. The wrap is explicit, so non-power-of-two `N_CORES` works.
- **ACCESS, write:** `mem_wren` = 1 and `ack[sel]` = 1 in this cycle; go to IDLE.
- **ACCESS, read:** `mem_wren` = 0; go to WAIT. Skip WAIT and go straight to RESP when `READ_LAT` = 1.
- **WAIT:** count `READ_LAT`−1 cycles. `mem_addr` is held stable throughout.
- **RESP:** `rdata` holds `mem_rdata` as sampled at the end of the last ACCESS/WAIT cycle, and `ack[sel]` = 1; go to IDLE.
- **Unrequested cores:** no `ack` is ever produced for a core whose `req` is low.
- **Request changes during service:** changes on non-selected request lines during ACCESS/WAIT/RESP are ignored until the next IDLE.
- **`mem_wren`:** high for exactly one cycle per write, never during a read.
- **Reset values:** `ack` = 0, `rdata` = 0, `busy` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_wren` = 0; `ptr` = 0; state = IDLE.
- **Reset mid-operation:** the access is aborted. No `ack` is produced for it and `mem_wren` drops immediately (asynchronously). After release, arbitration restarts from `ptr` = 0.

## Timing
All cycle numbers are relative to T, the IDLE cycle in which `req` is sampled.
- **Write:** `mem_wren` and `ack` in T+1. Next arbitration in T+2. Sustained write throughput is 1 per 2 cycles.
- **Read:** address on `mem_addr` from T+1. Data is sampled at the end of T+`READ_LAT`. `ack` and `rdata` in T+1+`READ_LAT`. Next arbitration in T+2+`READ_LAT`.
- **`busy`:** high from T+1 through the ack cycle.
- **Input-to-output paths:** none are combinational; every output is registered.

## Configuration
- **`MEMARB_CONTENTION_CNT_EN` defined:**
  - Adds output `contention_cnt` (out, 16 bits), reset 0.
  - Increments in every cycle where any `req[i]` is high and core i is not being acked in that cycle.
  - Saturates at 0xFFFF.
- **Not defined:** the port and the counter logic are absent.

## Structure
- **Package `tinygpu_mem_pkg`:**
  - default `ADDR_W`/`DATA_W` constants;
  - typedef `arb_state_t` {IDLE, ACCESS, WAIT, RESP};
  - a wait-counter width constant derived via `$clog2(READ_LAT+1)`.
- **Sub-module `rr_pick`:** combinational round-robin priority encoder. Inputs are `req` and `ptr`; outputs are `sel` and `any`. It is reusable elsewhere for core scheduling.

## Test plan
- **Single read:** `READ_LAT`=1; core 2 reads 0x0010; memory model returns 0xBEEF → `ack` = 4'b0100 and `rdata` = 0xBEEF at T+2; `mem_wren` never high.
- **Single write:** core 0 writes 0x1234 to 0x0020 → in T+1, `mem_wren` = 1, `mem_addr` = 0x0020, `mem_wdata` = 0x1234 and `ack` = 4'b0001.
- **Round-robin order:** all four cores write simultaneously → acks in order 0, 1, 2, 3 at T+1, T+3, T+5, T+7. Then cores 3 and 0 request together → grant order 0, 3.
- **Mid-read reset:** `READ_LAT`=3; assert `reset_n` low during WAIT of core 1's read → no `ack[1]`, all outputs 0. After release, a core 1 request completes normally.
- **Back-to-back reads:** `READ_LAT`=3; cores 1 and 3 both read → `ack[1]` at T+4, `ack[3]` at T+9, each with correct data.
- **Contention counter:** with `MEMARB_CONTENTION_CNT_EN`, two cores write together → `contention_cnt` = 3 after both acks.

Source files
------------

// File: rtl/tinygpu_mem_pkg.sv
// Shared types and constants for the tinygpu data-memory arbiter.
package tinygpu_mem_pkg;

  localparam int unsigned DefaultAddrW   = 16;
  localparam int unsigned DefaultDataW   = 16;
  localparam int unsigned DefaultReadLat = 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;

  // Wait counter must be able to hold READ_LAT.
  function automatic int unsigned wait_cnt_w(input int unsigned read_lat);
    return $clog2(read_lat + 1);
  endfunction

  localparam int unsigned DefaultWaitCntW = $clog2(DefaultReadLat + 1);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first requester at index >= ptr,
// wrapping modulo N. Works for any N >= 2, not only powers of two.
module rr_pick #(
  parameter  int unsigned N    = 4,
  localparam int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [PtrW-1:0] sel,
  output logic            any
);

  // Scan from ptr upward with explicit wrap; first hit wins.
  always_comb begin
    int unsigned idx;
    sel = '0;
    any = 1'b0;
    idx = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = PtrW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among N_CORES requesters.
// Optional feature: define MEMARB_CONTENTION_CNT_EN to add the 16-bit saturating
// contention_cnt output.
module mem_rr_arbiter
  import tinygpu_mem_pkg::*;
#(
  parameter int unsigned N_CORES  = 4,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned READ_LAT = DefaultReadLat
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_CORES-1:0]          req,
  input  logic [N_CORES-1:0]          we,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  input  logic [N_CORES*DATA_W-1:0]   wdata,
  output logic [N_CORES-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wren,
  input  logic [DATA_W-1:0]           mem_rdata
`ifdef MEMARB_CONTENTION_CNT_EN
  , output logic [15:0]               contention_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(N_CORES);
  localparam int unsigned CntW = wait_cnt_w(READ_LAT);

  arb_state_t          state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d, sel_q, sel_d, pick_sel;
  logic                pick_any;
  logic                we_q, we_d;
  logic [CntW-1:0]     wait_q, wait_d;
  logic [N_CORES-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wren_q, wren_d, busy_q;
  logic [ADDR_W-1:0]   core_addr  [N_CORES];
  logic [DATA_W-1:0]   core_wdata [N_CORES];

  // Unpack the flattened per-core address and write-data buses.
  always_comb begin
    for (int unsigned i = 0; i < N_CORES; i++) begin
      core_addr[i]  = addr[i*ADDR_W +: ADDR_W];
      core_wdata[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(
    .N(N_CORES)
  ) u_pick (
    .req(req),
    .ptr(ptr_q),
    .sel(pick_sel),
    .any(pick_any)
  );

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wait_d  = wait_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_sel;
          we_d    = we[pick_sel];
          addr_d  = core_addr[pick_sel];
          wdata_d = core_wdata[pick_sel];
          wren_d  = we[pick_sel];
          // A write completes in the access cycle itself.
          ack_d[pick_sel] = we[pick_sel];
          ptr_d   = (pick_sel == PtrW'(N_CORES - 1)) ? '0 : pick_sel + PtrW'(1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else if (READ_LAT == 1) begin
          rdata_d       = mem_rdata;
          ack_d[sel_q]  = 1'b1;
          state_d       = RESP;
        end else begin
          wait_d  = CntW'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == CntW'(READ_LAT - 1)) begin
          rdata_d      = mem_rdata;
          ack_d[sel_q] = 1'b1;
          state_d      = RESP;
        end else begin
          wait_d = wait_q + CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wait_q  <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wren  = wren_q;

`ifdef MEMARB_CONTENTION_CNT_EN
  logic [15:0] cnt_q;

  // Count cycles where some core is requesting but not being acked; saturate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if ((|(req & ~ack_q)) && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign contention_cnt = cnt_q;
`else
  // No contention counter in this build.
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus randomized
// traffic against a transaction-level schedule model. Two DUTs (READ_LAT 1 and 3)
// are exercised one at a time; the idle one is held in reset.
module tb_mem_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n1, rst_n3;
  logic [N-1:0]      req, we;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      ack1, ack3;
  logic [DW-1:0]     rdata1, rdata3, mwd1, mwd3, mrd1, mrd3;
  logic [AW-1:0]     maddr1, maddr3;
  logic              busy1, busy3, mwren1, mwren3;
`ifdef MEMARB_CONTENTION_CNT_EN
  logic [15:0]       cc1, cc3, ccnt;
`endif

  int lat;
  logic [N-1:0]  ack;
  logic [DW-1:0] rdata, mwd;
  logic [AW-1:0] maddr;
  logic          busy, mwren;

  int vectors = 0;
  int errors  = 0;

  always_comb begin
    ack   = (lat == 1) ? ack1   : ack3;
    rdata = (lat == 1) ? rdata1 : rdata3;
    mwd   = (lat == 1) ? mwd1   : mwd3;
    maddr = (lat == 1) ? maddr1 : maddr3;
    busy  = (lat == 1) ? busy1  : busy3;
    mwren = (lat == 1) ? mwren1 : mwren3;
`ifdef MEMARB_CONTENTION_CNT_EN
    ccnt  = (lat == 1) ? cc1    : cc3;
`endif
  end

  // Memory device: combinational for latency 1, two address stages for latency 3.
  logic [DW-1:0] dev_mem [256];
  logic          poke_en;
  logic [7:0]    poke_a;
  logic [DW-1:0] poke_d;
  logic [AW-1:0] a3_d1, a3_d2;

  always @(posedge clk) begin
    if (poke_en) dev_mem[poke_a] <= poke_d;
    else if (mwren1) dev_mem[maddr1[7:0]] <= mwd1;
    else if (mwren3) dev_mem[maddr3[7:0]] <= mwd3;
    a3_d1 <= maddr3;
    a3_d2 <= a3_d1;
  end

  assign mrd1 = dev_mem[maddr1[7:0]];
  assign mrd3 = dev_mem[a3_d2[7:0]];

  mem_rr_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(rst_n1), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack1), .rdata(rdata1), .busy(busy1), .mem_addr(maddr1), .mem_wdata(mwd1),
    .mem_wren(mwren1), .mem_rdata(mrd1)
`ifdef MEMARB_CONTENTION_CNT_EN
    , .contention_cnt(cc1)
`endif
  );

  mem_rr_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(rst_n3), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack3), .rdata(rdata3), .busy(busy3), .mem_addr(maddr3), .mem_wdata(mwd3),
    .mem_wren(mwren3), .mem_rdata(mrd3)
`ifdef MEMARB_CONTENTION_CNT_EN
    , .contention_cnt(cc3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_core(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    step();
    poke_en = 1'b0;
  endtask

  // Reset both DUTs, then release only the one under test.
  task automatic reset_dut(input int l);
    lat = l;
    drive_idle();
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    step(); step();
    if (l == 1) rst_n1 = 1'b1; else rst_n3 = 1'b1;
  endtask

  task automatic test_reset(input int l);
    lat = l;
    drive_idle();
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    #1;
    vectors++;
    if ({ack, rdata, busy, maddr, mwd, mwren} !== '0) begin
      errors++;
      $display("FAIL reset_in lat%0d: got ack=%b rdata=%h busy=%b addr=%h wdata=%h wren=%b, all 0 required",
               l, ack, rdata, busy, maddr, mwd, mwren);
    end
    step();
    if (l == 1) rst_n1 = 1'b1; else rst_n3 = 1'b1;
    step();
    vectors++;
    if ({ack, rdata, busy, maddr, mwd, mwren} !== '0) begin
      errors++;
      $display("FAIL reset_after lat%0d: got ack=%b rdata=%h busy=%b addr=%h wdata=%h wren=%b, all 0 required",
               l, ack, rdata, busy, maddr, mwd, mwren);
    end
  endtask

  task automatic test_single_read();
    reset_dut(1);
    poke(8'h10, 16'hBEEF);
    set_core(2, 1'b0, 16'h0010, 16'h0000);
    step();  // T+1
    vectors++;
    if ({ack, busy, maddr, mwren} !== {4'b0000, 1'b1, 16'h0010, 1'b0}) begin
      errors++;
      $display("FAIL read_t1: got ack=%b busy=%b addr=%h wren=%b, required 0000 1 0010 0",
               ack, busy, maddr, mwren);
    end
    step();  // T+2
    vectors++;
    if ({ack, rdata, mwren} !== {4'b0100, 16'hBEEF, 1'b0}) begin
      errors++;
      $display("FAIL read_t2: got ack=%b rdata=%h wren=%b, required 0100 beef 0",
               ack, rdata, mwren);
    end
    drive_idle();
    step();  // T+3
    vectors++;
    if ({ack, busy, mwren} !== 6'b0) begin
      errors++;
      $display("FAIL read_t3: got ack=%b busy=%b wren=%b, required all 0", ack, busy, mwren);
    end
  endtask

  task automatic test_single_write();
    reset_dut(1);
    set_core(0, 1'b1, 16'h0020, 16'h1234);
    step();  // T+1
    vectors++;
    if ({mwren, maddr, mwd, ack} !== {1'b1, 16'h0020, 16'h1234, 4'b0001}) begin
      errors++;
      $display("FAIL write_t1: got wren=%b addr=%h wdata=%h ack=%b, required 1 0020 1234 0001",
               mwren, maddr, mwd, ack);
    end
    drive_idle();
    step();  // T+2
    vectors++;
    if ({mwren, ack, busy, dev_mem[8'h20]} !== {1'b0, 4'b0000, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL write_t2: got wren=%b ack=%b busy=%b mem[20]=%h, required 0 0000 0 1234",
               mwren, ack, busy, dev_mem[8'h20]);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    reset_dut(1);
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 16'(16'h0040 + i), 16'(16'hA000 + i));
    for (int c = 1; c <= 8; c++) begin
      step();
      exp = (c % 2 == 1) ? 4'(1 << ((c - 1) / 2)) : 4'b0000;
      vectors++;
      if (ack !== exp) begin
        errors++;
        $display("FAIL rr_all T+%0d: got ack=%b required %b", c, ack, exp);
      end
      req = req & ~ack;
    end
    set_core(3, 1'b1, 16'h0053, 16'hB003);
    set_core(0, 1'b1, 16'h0050, 16'hB000);
    for (int c = 1; c <= 4; c++) begin
      step();
      exp = (c == 1) ? 4'b0001 : (c == 3) ? 4'b1000 : 4'b0000;
      vectors++;
      if (ack !== exp) begin
        errors++;
        $display("FAIL rr_pair T+%0d: got ack=%b required %b", c, ack, exp);
      end
      req = req & ~ack;
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp;
    reset_dut(3);
    poke(8'h31, 16'h1111);
    poke(8'h33, 16'h3333);
    set_core(1, 1'b0, 16'h0031, 16'h0000);
    set_core(3, 1'b0, 16'h0033, 16'h0000);
    for (int c = 1; c <= 11; c++) begin
      step();
      exp = (c == 4) ? 4'b0010 : (c == 9) ? 4'b1000 : 4'b0000;
      vectors++;
      if (ack !== exp) begin
        errors++;
        $display("FAIL b2b_ack T+%0d: got %b required %b", c, ack, exp);
      end
      if (exp != 0) begin
        vectors++;
        if (rdata !== ((c == 4) ? 16'h1111 : 16'h3333)) begin
          errors++;
          $display("FAIL b2b_rdata T+%0d: got %h required %h", c, rdata,
                   (c == 4) ? 16'h1111 : 16'h3333);
        end
      end
      req = req & ~ack;
    end
  endtask

  task automatic test_mid_read_reset();
    logic [N-1:0] exp;
    reset_dut(3);
    poke(8'h31, 16'h5A5A);
    set_core(1, 1'b0, 16'h0031, 16'h0000);
    step();  // ACCESS
    step();  // WAIT
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got %b required 1", busy);
    end
    rst_n3 = 1'b0;
    #1;
    vectors++;
    if ({ack, rdata, busy, maddr, mwd, mwren} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got ack=%b rdata=%h busy=%b addr=%h wren=%b, all 0 required",
               ack, rdata, busy, maddr, mwren);
    end
    step(); step();
    vectors++;
    if ({ack, busy, mwren} !== '0) begin
      errors++;
      $display("FAIL midrst_held: got ack=%b busy=%b wren=%b, all 0 required", ack, busy, mwren);
    end
    rst_n3 = 1'b1;  // core 1 still requesting: this cycle is the new T
    for (int c = 1; c <= 5; c++) begin
      step();
      exp = (c == 4) ? 4'b0010 : 4'b0000;
      vectors++;
      if (ack !== exp) begin
        errors++;
        $display("FAIL midrst_retry T+%0d: got ack=%b required %b", c, ack, exp);
      end
      if (exp != 0) begin
        vectors++;
        if (rdata !== 16'h5A5A) begin
          errors++;
          $display("FAIL midrst_rdata: got %h required 5a5a", rdata);
        end
      end
      req = req & ~ack;
    end
  endtask

`ifdef MEMARB_CONTENTION_CNT_EN
  task automatic test_contention();
    reset_dut(1);
    set_core(0, 1'b1, 16'h0060, 16'hC000);
    set_core(1, 1'b1, 16'h0061, 16'hC001);
    for (int c = 1; c <= 5; c++) begin
      step();
      req = req & ~ack;
    end
    vectors++;
    if (ccnt !== 16'd3) begin
      errors++;
      $display("FAIL contention: got %0d required 3", ccnt);
    end
  endtask
`endif

  // Random traffic: model computes the grant schedule from the round-robin rule
  // and fixed access durations, and tracks memory contents per transaction.
  task automatic test_random(input int l, input int ncyc);
    logic [DW-1:0] ref_mem [256];
    int            ptr_m = 0, g_core = 0, t_grant = 0, ack_cyc = 0, cnt_m = 0, idx;
    bit            gvalid = 0, g_we = 0, exp_busy, exp_wren, found;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_wdata = '0, exp_rd = '0;
    logic [N-1:0]  exp_ack;
    reset_dut(l);
    for (int k = 0; k < 256; k++) ref_mem[k] = dev_mem[k];
    for (int c = 0; c < ncyc; c++) begin
      exp_ack = '0;
      if (gvalid && c == ack_cyc) exp_ack[g_core] = 1'b1;
      exp_busy = gvalid && c > t_grant && c <= ack_cyc;
      exp_wren = gvalid && g_we && c == t_grant + 1;
      vectors++;
      if ({ack, busy, mwren} !== {exp_ack, exp_busy, exp_wren}) begin
        errors++;
        $display("FAIL rand%0d_ctl cyc %0d: got ack=%b busy=%b wren=%b required %b %b %b",
                 l, c, ack, busy, mwren, exp_ack, exp_busy, exp_wren);
      end
      if (gvalid && c > t_grant && c <= t_grant + (g_we ? 1 : l)) begin
        vectors++;
        if (maddr !== g_addr) begin
          errors++;
          $display("FAIL rand%0d_addr cyc %0d: got %h required %h", l, c, maddr, g_addr);
        end
      end
      if (exp_wren) begin
        vectors++;
        if (mwd !== g_wdata) begin
          errors++;
          $display("FAIL rand%0d_wdata cyc %0d: got %h required %h", l, c, mwd, g_wdata);
        end
      end
      if (exp_ack != 0 && !g_we) begin
        vectors++;
        if (rdata !== exp_rd) begin
          errors++;
          $display("FAIL rand%0d_rdata cyc %0d: got %h required %h", l, c, rdata, exp_rd);
        end
      end
`ifdef MEMARB_CONTENTION_CNT_EN
      vectors++;
      if (ccnt !== 16'(cnt_m)) begin
        errors++;
        $display("FAIL rand%0d_cnt cyc %0d: got %0d required %0d", l, c, ccnt, cnt_m);
      end
`endif
      // Requester agents: drop on completion, otherwise maybe start a new access.
      for (int i = 0; i < N; i++) begin
        if (exp_ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0)
          set_core(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
      end
      // Arbitration point when the model says the arbiter is idle.
      if (!gvalid && (|req)) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (ptr_m + k) % N;
          if (!found && req[idx]) begin
            found   = 1;
            g_core  = idx;
          end
        end
        ptr_m   = (g_core + 1) % N;
        gvalid  = 1;
        t_grant = c;
        g_we    = we[g_core];
        g_addr  = addr[g_core*AW +: AW];
        g_wdata = wdata[g_core*DW +: DW];
        ack_cyc = g_we ? c + 1 : c + 1 + l;
        if (g_we) ref_mem[g_addr[7:0]] = g_wdata;
        else exp_rd = ref_mem[g_addr[7:0]];
      end
      if ((|(req & ~exp_ack)) && cnt_m < 65535) cnt_m++;
      if (gvalid && c == ack_cyc) gvalid = 0;
      step();
    end
    drive_idle();
  endtask

  initial begin
    rst_n1 = 1'b0; rst_n3 = 1'b0; lat = 1;
    poke_en = 1'b0; poke_a = '0; poke_d = '0;
    drive_idle();
    test_reset(1);
    test_reset(3);
    test_single_read();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_mid_read_reset();
`ifdef MEMARB_CONTENTION_CNT_EN
    test_contention();
`endif
    test_random(1, 600);
    test_random(3, 600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
